// File: rtl/ex_stage.sv
// ex_stage: RV32 execute stage with forwarding, ALU, branch resolution and iterative mul/div
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [XLEN-1:0] rd1E_i,
    input  logic [XLEN-1:0] rd2E_i,
    input  logic [XLEN-1:0] pcE_i,
    input  logic [XLEN-1:0] immextE_i,
    input  logic [XLEN-1:0] resultW_i,
    input  logic [XLEN-1:0] aluresultM_i,
    input  logic [1:0]      fwdAE_i,
    input  logic [1:0]      fwdBE_i,
    input  logic            alusrcE_i,
    input  logic [3:0]      alucontrolE_i,
    input  logic            branchE_i,
    input  logic            jumpE_i,
    input  logic            jalrE_i,
    input  logic [2:0]      funct3E_i,
    input  logic            mdvalidE_i,
    input  logic [2:0]      mdopE_i,
    output logic [XLEN-1:0] aluresultE_o,
    output logic [XLEN-1:0] writedataE_o,
    output logic [XLEN-1:0] pctargetE_o,
    output logic            pcsrcE_o,
    output logic            stallE_o
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

    md_state_t   state;
    logic [5:0]  cnt;
    logic [63:0] acc_q;
    logic [31:0] opnd_q;
    logic [2:0]  op_q;
    logic        neg_q_q;
    logic        neg_r_q;

    logic [31:0] src_a, fwd_b, src_b, alu_res, md_res;
    logic [4:0]  shamt;
    logic        cond;

    assign fwd_b        = (fwdBE_i == 2'b01) ? resultW_i : (fwdBE_i == 2'b10) ? aluresultM_i : rd2E_i;
    assign src_a        = (fwdAE_i == 2'b01) ? resultW_i : (fwdAE_i == 2'b10) ? aluresultM_i : rd1E_i;
    assign src_b        = alusrcE_i ? immextE_i : fwd_b;
    assign shamt        = src_b[4:0];
    assign writedataE_o = fwd_b;

    // ALU operation select
    always_comb begin
        alu_res = 32'd0;
        case (alucontrolE_i)
            4'd0:  alu_res = src_a + src_b;
            4'd1:  alu_res = src_a - src_b;
            4'd2:  alu_res = src_a & src_b;
            4'd3:  alu_res = src_a | src_b;
            4'd4:  alu_res = src_a ^ src_b;
            4'd5:  alu_res = {31'd0, $signed(src_a) < $signed(src_b)};
            4'd6:  alu_res = {31'd0, src_a < src_b};
            4'd7:  alu_res = src_a << shamt;
            4'd8:  alu_res = src_a >> shamt;
            4'd9:  alu_res = $signed(src_a) >>> shamt;
            4'd10: alu_res = src_b;
            default: alu_res = 32'd0;
        endcase
    end

    // Branch condition compares the forwarded register operands, never the immediate
    always_comb begin
        cond = 1'b0;
        case (funct3E_i)
            3'b000: cond = src_a == fwd_b;
            3'b001: cond = src_a != fwd_b;
            3'b100: cond = $signed(src_a) < $signed(fwd_b);
            3'b101: cond = $signed(src_a) >= $signed(fwd_b);
            3'b110: cond = src_a < fwd_b;
            3'b111: cond = src_a >= fwd_b;
            default: cond = 1'b0;
        endcase
    end

    assign pcsrcE_o    = jumpE_i | jalrE_i | (branchE_i & cond);
    assign pctargetE_o = jalrE_i ? ((src_a + immextE_i) & ~32'd1) : pcE_i + immextE_i;

    // Mul/div datapath: acc holds {hi, lo}; mul shifts the multiplier out of lo,
    // divide shifts the dividend out of lo while quotient bits shift in.
    logic        is_mul, in_signed, in_mul;
    logic [31:0] abs_a, abs_b;
    logic [32:0] mul_sum, div_sh;
    logic [31:0] div_diff;
    logic        div_ge;
    logic [63:0] acc_next;

    assign in_signed = mdopE_i[2] & ~mdopE_i[0];
    assign in_mul    = ~mdopE_i[2];
    assign abs_a     = (in_signed & src_a[31]) ? -src_a : src_a;
    assign abs_b     = (in_signed & fwd_b[31]) ? -fwd_b : fwd_b;
    assign is_mul    = ~op_q[2];
    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign div_sh    = {acc_q[63:32], acc_q[31]};
    assign div_ge    = div_sh >= {1'b0, opnd_q};
    assign div_diff  = div_sh[31:0] - opnd_q;
    assign acc_next  = is_mul ? {mul_sum, acc_q[31:1]}
                     : div_ge ? {div_diff, acc_q[30:0], 1'b1}
                     : {div_sh[31:0], acc_q[30:0], 1'b0};

    // Final result selection with sign fix-up for signed divide/remainder
    always_comb begin
        md_res = 32'd0;
        case (op_q)
            3'b000: md_res = acc_q[31:0];
            3'b001: md_res = acc_q[63:32];
            3'b100, 3'b101: md_res = neg_q_q ? -acc_q[31:0] : acc_q[31:0];
            3'b110, 3'b111: md_res = neg_r_q ? -acc_q[63:32] : acc_q[63:32];
            default: md_res = 32'd0;
        endcase
    end

    // Mul/div sequencer: latch operands, 32 iteration steps, one result cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= 6'd0;
            acc_q   <= 64'd0;
            opnd_q  <= 32'd0;
            op_q    <= 3'd0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (mdvalidE_i) begin
                    acc_q   <= {32'd0, in_mul ? abs_b : abs_a};
                    opnd_q  <= in_mul ? abs_a : abs_b;
                    op_q    <= mdopE_i;
                    neg_q_q <= in_signed & (src_a[31] ^ fwd_b[31]) & (fwd_b != 32'd0);
                    neg_r_q <= in_signed & src_a[31];
                    cnt     <= 6'd0;
                    state   <= BUSY;
                end
                BUSY: begin
                    acc_q <= acc_next;
                    cnt   <= cnt + 6'd1;
                    if (cnt == 6'd31) state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign stallE_o     = mdvalidE_i & (state != DONE);
    assign aluresultE_o = (mdvalidE_i & (state == DONE)) ? md_res : alu_res;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed self-checking bench for the execute stage
module tb_ex_stage;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] rd1E_i, rd2E_i, pcE_i, immextE_i, resultW_i, aluresultM_i;
    logic [1:0]  fwdAE_i, fwdBE_i;
    logic        alusrcE_i, branchE_i, jumpE_i, jalrE_i, mdvalidE_i;
    logic [3:0]  alucontrolE_i;
    logic [2:0]  funct3E_i, mdopE_i;
    logic [31:0] aluresultE_o, writedataE_o, pctargetE_o;
    logic        pcsrcE_o, stallE_o;
    int          tests = 0;
    int          fails = 0;

    ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .rd1E_i(rd1E_i), .rd2E_i(rd2E_i), .pcE_i(pcE_i), .immextE_i(immextE_i),
        .resultW_i(resultW_i), .aluresultM_i(aluresultM_i),
        .fwdAE_i(fwdAE_i), .fwdBE_i(fwdBE_i), .alusrcE_i(alusrcE_i),
        .alucontrolE_i(alucontrolE_i), .branchE_i(branchE_i), .jumpE_i(jumpE_i),
        .jalrE_i(jalrE_i), .funct3E_i(funct3E_i), .mdvalidE_i(mdvalidE_i),
        .mdopE_i(mdopE_i), .aluresultE_o(aluresultE_o), .writedataE_o(writedataE_o),
        .pctargetE_o(pctargetE_o), .pcsrcE_o(pcsrcE_o), .stallE_o(stallE_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts stall cycles from the current (T0) cycle, then checks the result cycle
    task automatic md_wait(input string tag, input logic [31:0] exp);
        int n = 0;
        #1;
        while (stallE_o === 1'b1 && n < 100) begin
            n++;
            @(negedge clk_i);
            rd1E_i = 32'hDEADBEEF;
            rd2E_i = 32'h0;
            #1;
        end
        check({tag, "_cycles"}, n, 33);
        check(tag, aluresultE_o, exp);
        @(negedge clk_i);
        mdvalidE_i = 1'b0;
    endtask

    task automatic md_run(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk_i);
        rd1E_i = a; rd2E_i = b; fwdAE_i = 2'b00; fwdBE_i = 2'b00; alusrcE_i = 1'b0;
        mdopE_i = op; mdvalidE_i = 1'b1;
        md_wait(tag, exp);
    endtask

    initial begin
        rst_i = 1'b1;
        rd1E_i = 0; rd2E_i = 0; pcE_i = 0; immextE_i = 0; resultW_i = 0; aluresultM_i = 0;
        fwdAE_i = 0; fwdBE_i = 0; alusrcE_i = 0; alucontrolE_i = 0; branchE_i = 0;
        jumpE_i = 0; jalrE_i = 0; funct3E_i = 0; mdvalidE_i = 0; mdopE_i = 0;
        repeat (2) @(negedge clk_i);
        check("rst_stall", {31'd0, stallE_o}, 0);
        check("rst_alu", aluresultE_o, 0);
        check("rst_pcsrc", {31'd0, pcsrcE_o}, 0);
        rst_i = 1'b0;

        rd1E_i = 5; fwdAE_i = 2'b10; aluresultM_i = 32'h10; immextE_i = 3; alusrcE_i = 1;
        #1;
        check("add_fwdM_imm", aluresultE_o, 32'h13);
        check("add_stall", {31'd0, stallE_o}, 0);
        fwdAE_i = 2'b00; alusrcE_i = 0; rd1E_i = 3; rd2E_i = 5; alucontrolE_i = 4'd1;
        #1 check("sub_wrap", aluresultE_o, 32'hFFFFFFFE);
        rd1E_i = 32'h80000000; rd2E_i = 32'h24; alucontrolE_i = 4'd9;
        #1 check("sra", aluresultE_o, 32'hF8000000);
        alucontrolE_i = 4'd8;
        #1 check("srl", aluresultE_o, 32'h08000000);
        alucontrolE_i = 4'd5;
        #1 check("slt", aluresultE_o, 32'd1);
        alucontrolE_i = 4'd6;
        #1 check("sltu", aluresultE_o, 32'd0);
        alucontrolE_i = 4'd12;
        #1 check("op_invalid", aluresultE_o, 32'd0);
        fwdBE_i = 2'b01; resultW_i = 32'hCAFE0001; alucontrolE_i = 4'd10;
        #1 check("fwdW_store", writedataE_o, 32'hCAFE0001);
        check("passb", aluresultE_o, 32'hCAFE0001);

        fwdBE_i = 2'b00; rd1E_i = 32'hFFFFFFFF; rd2E_i = 1; pcE_i = 32'h100; immextE_i = 32'h20;
        branchE_i = 1; funct3E_i = 3'b100;
        #1 check("blt_taken", {31'd0, pcsrcE_o}, 1);
        check("blt_target", pctargetE_o, 32'h120);
        funct3E_i = 3'b110;
        #1 check("bltu_not", {31'd0, pcsrcE_o}, 0);
        funct3E_i = 3'b010;
        #1 check("bcond_invalid", {31'd0, pcsrcE_o}, 0);
        branchE_i = 0; jalrE_i = 1; rd1E_i = 32'h1001; immextE_i = 4;
        #1 check("jalr_target", pctargetE_o, 32'h1004);
        check("jalr_pcsrc", {31'd0, pcsrcE_o}, 1);
        jalrE_i = 0; immextE_i = 0; alucontrolE_i = 0;

        md_run("div_neg", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        md_run("rem_neg", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        md_run("mulhu_max", 3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        md_run("mul_neg", 3'b000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1);
        md_run("divu_zero", 3'b101, 32'd10, 32'd0, 32'hFFFFFFFF);
        md_run("remu_zero", 3'b111, 32'd10, 32'd0, 32'd10);
        md_run("div_zero_neg", 3'b100, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF);
        md_run("rem_zero_neg", 3'b110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9);
        md_run("div_ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        md_run("rem_ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0);
        md_run("divu", 3'b101, 32'd100, 32'd7, 32'd14);

        @(negedge clk_i);
        rd1E_i = 6; rd2E_i = 7; mdopE_i = 3'b000; mdvalidE_i = 1'b1;
        repeat (11) @(negedge clk_i);
        rst_i = 1'b1;
        #1 check("rst_busy_stall", {31'd0, stallE_o}, 1);
        @(negedge clk_i);
        rst_i = 1'b0;
        md_wait("mul_after_rst", 32'd42);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage RV32 pipeline: consumes the ID/EX register outputs, applies forwarding, evaluates the ALU op and branch/jump target, and produces the values captured by the EX/MEM register. RV32M MUL/MULHU/DIV/DIVU/REM/REMU run on an internal iterative unit that stalls the front of the pipeline until the result is ready. Everything except the mul/div unit is combinational.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; one clock domain, synchronous, active-high.
- rd1E_i, rd2E_i  in  32 each  register operands from ID/EX.
- pcE_i, immextE_i  in  32 each  instruction PC and extended immediate.
- resultW_i, aluresultM_i  in  32 each  forwarding sources from WB and MEM.
- fwdAE_i, fwdBE_i  in  2 each  operand select: 00 register, 01 resultW_i, 10 aluresultM_i, 11 register.
- alusrcE_i  in  1  operand B: 0 forwarded rd2, 1 immextE_i.
- alucontrolE_i  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 PASSB; 11-15 give 0.
- branchE_i, jumpE_i, jalrE_i  in  1 each  conditional branch, JAL, JALR.
- funct3E_i  in  3  branch condition: 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; others never taken.
- mdvalidE_i  in  1  instruction is an M-extension op.
- mdopE_i  in  3  000 MUL, 001 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU; others give 0.
- aluresultE_o  out  32  ALU or mul/div result to EX/MEM.
- writedataE_o  out  32  forwarded rd2 (store data).
- pctargetE_o  out  32  redirect target.
- pcsrcE_o  out  1  take redirect.
- stallE_o  out  1  hold PC, IF/ID, ID/EX; bubble EX/MEM.

## Operation
- srcA = fwdAE mux; fwdB = fwdBE mux; srcB = alusrcE_i ? immextE_i : fwdB; writedataE_o = fwdB.
- Shifts use srcB[4:0]; SRA arithmetic; SLT signed, SLTU unsigned; ADD/SUB wrap mod 2^32.
- Branch compare on srcA vs fwdB. pcsrcE_o = jumpE_i | jalrE_i | (branchE_i & cond).
- pctargetE_o = jalrE_i ? (srcA + immextE_i) & ~1 : pcE_i + immextE_i.
- Mul/div FSM states IDLE, BUSY, DONE; 6-bit counter cnt.
- IDLE, mdvalidE_i=1: latch |srcA|,|fwdB| (signed ops; signed DIV takes divisor sign from fwdB), result signs, op; cnt<=0; go BUSY.
- BUSY: one shift-add (MUL/MULHU, 64-bit product) or one restoring-divide step per cycle; cnt++; after cnt==31 step go DONE.
- DONE: result valid; next edge go IDLE unconditionally.
- stallE_o = mdvalidE_i & (state != DONE). pcsrcE_o is independent of stallE_o; M ops never assert branch/jump.
- aluresultE_o = (mdvalidE_i & state==DONE) ? mdresult : ALU result.
- MUL = product[31:0]; MULHU = product[63:32] (unsigned).
- DIV/REM signed: quotient negated if signs differ, remainder takes dividend sign.
- Divide by zero: quotient 0xFFFFFFFF (all ops), remainder = dividend; still 34-cycle path.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.

## Timing
- Reset: state IDLE, cnt 0, internal operand/accumulator registers 0. Combinational outputs follow inputs; stallE_o = mdvalidE_i in reset-exit cycle.
- ALU, branch, target: zero latency.
- M op present in cycle T0: stallE_o=1 in T0..T32 (33 cycles), 0 in T33 with result valid; ID/EX advances at end of T33. Total occupancy 34 cycles.
- Operands sampled once at end of T0; forwarding-source changes afterwards ignored.
- Back-to-back M ops: the second enters ID/EX at end of T33 while FSM returns to IDLE; it starts its own T0 next cycle.
- rst_i asserted mid-BUSY: next edge IDLE, cnt 0, partial result discarded; stallE_o recomputed from mdvalidE_i.
- mdvalidE_i dropping in BUSY (abnormal): FSM completes and discards result.

## Test plan
- ADD, rd1=5, fwdAE=10 with aluresultM=0x10, imm=3, alusrcE=1 -> aluresultE_o=0x13, stallE_o=0, same cycle.
- BLT srcA=0xFFFFFFFF, fwdB=1, pcE=0x100, imm=0x20 -> pcsrcE_o=1, pctargetE_o=0x120; BLTU same operands -> pcsrcE_o=0.
- JALR srcA=0x1001, imm=4 -> pctargetE_o=0x1004, pcsrcE_o=1.
- DIV -7/2 -> stallE_o high 33 cycles, then 0xFFFFFFFD; REM -> 0xFFFFFFFF; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- DIVU 10/0 -> 0xFFFFFFFF; REMU 10/0 -> 10; DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
- rst_i pulsed at BUSY cnt=10 -> FSM IDLE next edge; with mdvalidE_i held, fresh 34-cycle operation yields correct MUL 6*7=42.
